// File: rtl/multi_alarm_clock_pkg.sv
// Shared limits, channel state encoding and width helpers for the multi-alarm clock.
package multi_alarm_clock_pkg;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  // Bits needed to hold 0..max_val.
  function automatic int width_of(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to address n channels, never less than one.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: alarm time registers, match against the new time of day,
// and the IDLE/RINGING/SNOOZED controller with its snooze and ring countdowns.
module alarm_channel
  import multi_alarm_clock_pkg::*;
#(
  parameter int RING_SEC   = 300,
  parameter int SNOOZE_MIN = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       en,
  input  logic       edit_min,
  input  logic       edit_hr,
  input  logic       fire,
  input  logic [5:0] new_min,
  input  logic [4:0] new_hr,
  input  logic       snooze,
  input  logic       stop,
  output logic [5:0] alarm_min,
  output logic [4:0] alarm_hr,
  output logic [1:0] state_o
);

  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int RING_W    = width_of(RING_SEC);
  localparam int SNZ_W     = width_of(SNZ_TICKS);
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SEC);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNZ_TICKS);

  alarm_state_t      state_q, state_d;
  logic [5:0]        alarm_min_q, alarm_min_d;
  logic [4:0]        alarm_hr_q, alarm_hr_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic              match;

  always_comb begin
    alarm_min_d = alarm_min_q;
    alarm_hr_d  = alarm_hr_q;
    if (edit_min) alarm_min_d = (alarm_min_q == 6'(MIN_MAX)) ? 6'd0 : alarm_min_q + 6'd1;
    if (edit_hr)  alarm_hr_d  = (alarm_hr_q == 5'(HR_MAX)) ? 5'd0 : alarm_hr_q + 5'd1;
  end

  assign match = fire && (new_min == alarm_min_q) && (new_hr == alarm_hr_q);

  // Disarm, edit and STOP all dominate; SNOOZE only matters while ringing.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!en || edit_min || edit_hr || stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_d    = RINGING;
            ring_cnt_d = RING_LOAD;
          end
        end
        RINGING: begin
          if (snooze) begin
            state_d   = SNOOZED;
            snz_cnt_d = SNZ_LOAD;
          end else if (sec_tick) begin
            if (ring_cnt_q == RING_W'(1)) state_d = IDLE;
            ring_cnt_d = ring_cnt_q - RING_W'(1);
          end
        end
        SNOOZED: begin
          if (sec_tick) begin
            snz_cnt_d = snz_cnt_q - SNZ_W'(1);
            if (snz_cnt_q == SNZ_W'(1)) begin
              state_d    = RINGING;
              ring_cnt_d = RING_LOAD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alarm_min_q <= '0;
      alarm_hr_q  <= '0;
      ring_cnt_q  <= '0;
      snz_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      alarm_min_q <= alarm_min_d;
      alarm_hr_q  <= alarm_hr_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
    end
  end

  assign alarm_min = alarm_min_q;
  assign alarm_hr  = alarm_hr_q;
  assign state_o   = state_q;

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour time-of-day counter with NUM_ALARMS alarm channels, mode decode,
// display mux and buzzer reduction.
module multi_alarm_clock
  import multi_alarm_clock_pkg::SEC_MAX;
  import multi_alarm_clock_pkg::MIN_MAX;
  import multi_alarm_clock_pkg::HR_MAX;
  import multi_alarm_clock_pkg::sel_width;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 9,
  parameter int RING_SEC   = 300
) (
  input  logic                              CLK,
  input  logic                              CLR,
  input  logic                              SEC_TICK,
  input  logic                              SETUP_TIME,
  input  logic                              SETUP_ALARM,
  input  logic [sel_width(NUM_ALARMS)-1:0]  ALARM_SEL,
  input  logic                              MIN_ADV,
  input  logic                              HR_ADV,
  input  logic [NUM_ALARMS-1:0]             ALARM_EN,
  input  logic                              SNOOZE,
  input  logic                              STOP,
  output logic [5:0]                        SECONDS,
  output logic [5:0]                        MINUTES,
  output logic [4:0]                        HOURS,
  output logic [5:0]                        DISP_SECONDS,
  output logic [5:0]                        DISP_MINUTES,
  output logic [4:0]                        DISP_HOURS,
  output logic [NUM_ALARMS-1:0]             RINGING,
  output logic [NUM_ALARMS-1:0]             SNOOZED,
  output logic                              BUZZ
);

  localparam int SEL_W = sel_width(NUM_ALARMS);

  logic       time_mode, alarm_mode, fire;
  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic [5:0] ch_min [NUM_ALARMS];
  logic [4:0] ch_hr [NUM_ALARMS];
  logic [1:0] ch_state [NUM_ALARMS];

  assign time_mode  = SETUP_TIME & ~SETUP_ALARM;
  assign alarm_mode = SETUP_ALARM & ~SETUP_TIME;

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (time_mode) begin
      sec_d = 6'd0;
      if (MIN_ADV) min_d = (min_q == 6'(MIN_MAX)) ? 6'd0 : min_q + 6'd1;
      if (HR_ADV)  hr_d  = (hr_q == 5'(HR_MAX)) ? 5'd0 : hr_q + 5'd1;
    end else if (SEC_TICK) begin
      if (sec_q == 6'(SEC_MAX)) begin
        sec_d = 6'd0;
        if (min_q == 6'(MIN_MAX)) begin
          min_d = 6'd0;
          hr_d  = (hr_q == 5'(HR_MAX)) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  // Alarms compare against the time being loaded this cycle, so a match
  // lands on the same edge that shows hh:mm:00.
  assign fire = ~time_mode & SEC_TICK & (sec_d == 6'd0);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q  <= hr_d;
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    logic sel_hit;
    assign sel_hit = alarm_mode && (ALARM_SEL == SEL_W'(i));

    alarm_channel #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_MIN (SNOOZE_MIN)
    ) u_ch (
      .clk       (CLK),
      .rst_n     (CLR),
      .sec_tick  (SEC_TICK),
      .en        (ALARM_EN[i]),
      .edit_min  (sel_hit & MIN_ADV),
      .edit_hr   (sel_hit & HR_ADV),
      .fire      (fire),
      .new_min   (min_d),
      .new_hr    (hr_d),
      .snooze    (SNOOZE),
      .stop      (STOP),
      .alarm_min (ch_min[i]),
      .alarm_hr  (ch_hr[i]),
      .state_o   (ch_state[i])
    );

    assign RINGING[i] = (ch_state[i] == 2'(multi_alarm_clock_pkg::RINGING));
    assign SNOOZED[i] = (ch_state[i] == 2'(multi_alarm_clock_pkg::SNOOZED));
  end

  always_comb begin
    DISP_SECONDS = sec_q;
    DISP_MINUTES = min_q;
    DISP_HOURS   = hr_q;
    if (alarm_mode) begin
      DISP_SECONDS = 6'd0;
      DISP_MINUTES = 6'd0;
      DISP_HOURS   = 5'd0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (ALARM_SEL == SEL_W'(i)) begin
          DISP_MINUTES = ch_min[i];
          DISP_HOURS   = ch_hr[i];
        end
      end
    end
  end

  assign SECONDS = sec_q;
  assign MINUTES = min_q;
  assign HOURS   = hr_q;
  assign BUZZ    = |RINGING;

endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
- Parametrised successor to the single-alarm conventional alarm clock.
- Fully synchronous 24-hour time-of-day counter with NUM_ALARMS independent alarm channels, per-channel snooze and ring timeout, and a display mux.
- Time advances on a one-cycle SEC_TICK enable instead of a gated clock.
- Feeds the existing seven-segment decoders through DISP_* outputs.

Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..8).
- SNOOZE_MIN, 9, snooze length in minutes (1..30).
- RING_SEC, 300, seconds an unanswered alarm rings before auto-stop (1..3600).

Ports:
- CLK  in  1  system clock.
- CLR  in  1  asynchronous active-low reset.
- SEC_TICK  in  1  one-cycle pulse, once per second.
- SETUP_TIME  in  1  level; time-setting mode.
- SETUP_ALARM  in  1  level; alarm-setting mode for channel ALARM_SEL.
- ALARM_SEL  in  $clog2(NUM_ALARMS) (min 1)  alarm channel being set/displayed.
- MIN_ADV  in  1  one-cycle pulse; advance minutes of the selected target.
- HR_ADV  in  1  one-cycle pulse; advance hours of the selected target.
- ALARM_EN  in  NUM_ALARMS  per-channel arm, level.
- SNOOZE  in  1  one-cycle pulse.
- STOP  in  1  one-cycle pulse.
- SECONDS  out  6  current seconds 0..59.
- MINUTES  out  6  current minutes 0..59.
- HOURS  out  5  current hours 0..23.
- DISP_SECONDS  out  6  display seconds; 0 in alarm setup.
- DISP_MINUTES  out  6  time minutes, or the selected alarm's minutes in alarm setup.
- DISP_HOURS  out  5  time hours, or the selected alarm's hours in alarm setup.
- RINGING  out  NUM_ALARMS  per-channel ringing flag.
- SNOOZED  out  NUM_ALARMS  per-channel snoozed flag.
- BUZZ  out  1  OR of RINGING.

Behaviour:
- Reset (CLR=0, async): time 00:00:00, all alarm times 00:00, all channels IDLE, all outputs 0.
- Mode decode: time_mode = SETUP_TIME & ~SETUP_ALARM; alarm_mode = SETUP_ALARM & ~SETUP_TIME. Both high counts as run mode for counting but ignores MIN_ADV/HR_ADV.
- Run mode:
  - On SEC_TICK, seconds increments.
  - 59→0 carries to minutes; minutes 59→0 carries to hours; hours 23→0.
  - All time registers update in the same cycle.
- time_mode:
  - SEC_TICK is ignored and seconds is forced to 0.
  - MIN_ADV: minutes +1, wrapping 59→0 with no hour carry.
  - HR_ADV: hours +1, wrapping 23→0.
  - MIN_ADV and HR_ADV in the same cycle: both apply.
- alarm_mode:
  - MIN_ADV/HR_ADV edit only channel ALARM_SEL, with the same wrap rules.
  - An out-of-range ALARM_SEL is ignored.
  - Editing a channel forces it to IDLE.
  - Time keeps running.
- Trigger:
  - Fires on a run-mode SEC_TICK whose new value has seconds==0 and hours:minutes equal to channel i's alarm time, with ALARM_EN[i]=1.
  - A channel in IDLE goes to RINGING; a channel in RINGING or SNOOZED ignores it.
  - Setting time in time_mode never triggers.
- Channel FSM, states IDLE, RINGING, SNOOZED:
  - RINGING: ring counter loads RING_SEC on entry and decrements on SEC_TICK.
  - RINGING + SNOOZE → SNOOZED, snooze counter loads SNOOZE_MIN*60.
  - RINGING + ring counter reaching 0 → IDLE.
  - SNOOZED: snooze counter decrements on SEC_TICK, including during setup modes; reaching 0 → RINGING with the ring counter reloaded.
  - STOP, from RINGING or SNOOZED → IDLE.
  - ALARM_EN[i]=0 forces IDLE regardless of other inputs.
  - SNOOZE and STOP in the same cycle: STOP wins.
  - SNOOZE and STOP act on all channels; SNOOZE while SNOOZED has no effect.
- Latency: all outputs registered. RINGING/BUZZ assert the cycle after the triggering SEC_TICK and drop the cycle after STOP.
- DISP_* are combinational muxes of registered values.
- Counter widths: $clog2(max+1). No saturating arithmetic is needed because of the explicit wrap and zero checks.

Decomposition:
- Package multi_alarm_clock_pkg holds:
  - SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
  - Enum alarm_state_t {IDLE, RINGING, SNOOZED}.
  - A width helper function.
- Sub-module alarm_channel, one per channel via generate, contains:
  - the alarm time registers and set logic;
  - the match comparator;
  - the FSM;
  - the snooze and ring counters.
- The top level holds the time-of-day counter, mode decode, display mux and BUZZ reduction.

Test Plan:
- Reset, then 3661 SEC_TICKs → 01:01:01; from 23:59:59, one tick → 00:00:00.
- time_mode: 75 MIN_ADV → minutes 15 and hours unchanged; 25 HR_ADV → hours 1; SEC_TICKs ignored and seconds stays 0.
- Alarm ch2=06:30 with EN, time 06:29:59, tick → RINGING[2] and BUZZ one cycle later. Same setup with EN[2]=0 → no ring.
- Ringing ch0, SNOOZE, SNOOZE_MIN=1: ring returns exactly 60 ticks later. STOP+SNOOZE in the same cycle → IDLE.
- RING_SEC=5: no response → BUZZ drops after the 5th tick. Two channels at the same time both ring, and one STOP clears both.
- Assert CLR mid-ring and mid-snooze → all outputs 0 immediately (async); after release, time is 00:00:00 and nothing rings.
